wspr_tx_scheduler: RTL

//  Slot scheduler for wspr_generator. Uses GPS 1PPS and even-minute markers to

---
 rtl/wspr_pkg.sv | 22 ++
 rtl/wspr_tx_scheduler_event_counter.sv | 36 +++
 rtl/wspr_tx_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wspr_pkg.sv
// Shared definitions for the WSPR transmit slot scheduler: FSM encoding and
// WSPR protocol timing constants.
package wspr_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_MARK = 3'd1,
        S_OFFSET    = 3'd2,
        S_START     = 3'd3,
        S_ACK       = 3'd4,
        S_TX        = 3'd5
    } sched_state_t;

    localparam int WSPR_SYMBOLS       = 162;
    localparam int WSPR_SLOT_S        = 120;
    localparam int WSPR_START_DELAY_S = 1;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wspr_tx_scheduler_event_counter.sv
// Loadable down-counter with a zero flag; used for the skip counter, the pps
// counter and the ack timer of the slot scheduler.
module event_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] count_d, count_q;

    // Saturates at zero so a stray enable cannot wrap the terminal condition away.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/wspr_tx_scheduler.sv
// WSPR slot scheduler: starts the generator on even-minute marks (1 of every N
// slots), rotates the band per transmission and guards it with ack/TX watchdogs.
module wspr_tx_scheduler
    import wspr_pkg::*;
#(
    parameter int P_START_DELAY_S = WSPR_START_DELAY_S,
    parameter int P_ACK_TIMEOUT   = 1024,
    parameter int P_MAX_TX_S      = 115,
    parameter int P_BAND_W        = 3
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_enable,
    input  logic                i_pps,
    input  logic                i_evenMinute,
    input  logic [3:0]          i_txEvery,
    input  logic [P_BAND_W-1:0] i_numBands,
    input  logic                i_txBusy,
    output logic                o_txStart,
    output logic                o_txAbort,
    output logic [P_BAND_W-1:0] o_bandSel,
    output logic [2:0]          o_state,
    output logic [15:0]         o_txCount,
    output logic                o_error
);

    localparam int ACK_W = $clog2(P_ACK_TIMEOUT + 1);
    localparam int PPS_W = $clog2(max_of(P_MAX_TX_S, P_START_DELAY_S) + 1);
    localparam logic [ACK_W-1:0]    ACK_LOAD    = ACK_W'(P_ACK_TIMEOUT - 1);
    localparam logic [PPS_W-1:0]    OFFSET_LOAD = PPS_W'(max_of(P_START_DELAY_S - 1, 0));
    localparam logic [PPS_W-1:0]    TX_LOAD     = PPS_W'(P_MAX_TX_S - 1);
    localparam logic [P_BAND_W:0]   BAND_ONE    = (P_BAND_W + 1)'(1);

    sched_state_t          state_d, state_q;
    logic                  start_d, start_q;
    logic                  abort_d, abort_q;
    logic [P_BAND_W-1:0]   band_d, band_q;
    logic [15:0]           count_d, count_q;
    logic                  error_d, error_q;
    logic                  enable_q, busy_q;

    logic                  skip_load, skip_en, skip_zero;
    logic [3:0]            skip_val;
    logic                  pps_load, pps_en, pps_zero;
    logic [PPS_W-1:0]      pps_val;
    logic                  ack_load, ack_en, ack_zero;

    logic [P_BAND_W:0]     band_inc, band_lim;
    logic [P_BAND_W-1:0]   band_next;

    // A band index left beyond a shrunken rotation falls back to band 0.
    assign band_inc  = {1'b0, band_q} + BAND_ONE;
    assign band_lim  = (i_numBands == '0) ? BAND_ONE : {1'b0, i_numBands};
    assign band_next = (band_inc >= band_lim) ? '0 : band_inc[P_BAND_W-1:0];

    always_comb begin
        state_d   = state_q;
        abort_d   = 1'b0;
        band_d    = band_q;
        count_d   = count_q;
        error_d   = error_q;
        skip_load = 1'b0;
        skip_en   = 1'b0;
        skip_val  = 4'd0;
        pps_load  = 1'b0;
        pps_en    = 1'b0;
        pps_val   = '0;
        ack_en    = 1'b0;

        if (i_enable && !enable_q) begin
            error_d = 1'b0;
        end

        if (!i_enable) begin
            state_d = S_IDLE;
            abort_d = (state_q == S_ACK) || (state_q == S_TX);
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_WAIT_MARK;
                    skip_load = 1'b1;
                end
                S_WAIT_MARK: begin
                    if (i_evenMinute) begin
                        if (skip_zero) begin
                            skip_load = 1'b1;
                            skip_val  = (i_txEvery == 4'd0) ? 4'd0 : i_txEvery - 4'd1;
                            if (P_START_DELAY_S == 0) begin
                                state_d = S_START;
                            end else begin
                                state_d  = S_OFFSET;
                                pps_load = 1'b1;
                                pps_val  = OFFSET_LOAD;
                            end
                        end else begin
                            skip_en = 1'b1;
                        end
                    end
                end
                S_OFFSET: begin
                    if (i_pps) begin
                        if (pps_zero) begin
                            state_d = S_START;
                        end else begin
                            pps_en = 1'b1;
                        end
                    end
                end
                S_START: begin
                    state_d = S_ACK;
                    ack_en  = 1'b1;
                end
                S_ACK: begin
                    if (i_txBusy) begin
                        state_d  = S_TX;
                        pps_load = 1'b1;
                        pps_val  = TX_LOAD;
                    end else if (ack_zero) begin
                        state_d = S_WAIT_MARK;
                        abort_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        ack_en = 1'b1;
                    end
                end
                S_TX: begin
                    // Normal completion outranks a watchdog expiring in the same cycle.
                    if (busy_q && !i_txBusy) begin
                        state_d = S_WAIT_MARK;
                        count_d = count_q + 16'd1;
                        band_d  = band_next;
                    end else if (i_pps) begin
                        if (pps_zero) begin
                            state_d = S_WAIT_MARK;
                            abort_d = 1'b1;
                            error_d = 1'b1;
                            band_d  = band_next;
                        end else begin
                            pps_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // The ack timer is armed on entry to START so that cycle counts toward the timeout.
        start_d  = (state_d == S_START);
        ack_load = start_d;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            band_q   <= '0;
            count_q  <= 16'd0;
            error_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            band_q   <= band_d;
            count_q  <= count_d;
            error_q  <= error_d;
            enable_q <= i_enable;
            busy_q   <= i_txBusy;
        end
    end

    event_counter #(.W(4)) u_skip_cnt (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_load     (skip_load),
        .i_load_val (skip_val),
        .i_en       (skip_en),
        .o_zero     (skip_zero)
    );

    event_counter #(.W(PPS_W)) u_pps_cnt (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_load     (pps_load),
        .i_load_val (pps_val),
        .i_en       (pps_en),
        .o_zero     (pps_zero)
    );

    event_counter #(.W(ACK_W)) u_ack_cnt (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_load     (ack_load),
        .i_load_val (ACK_LOAD),
        .i_en       (ack_en),
        .o_zero     (ack_zero)
    );

    assign o_txStart = start_q;
    assign o_txAbort = abort_q;
    assign o_bandSel = band_q;
    assign o_state   = state_q;
    assign o_txCount = count_q;
    assign o_error   = error_q;

endmodule
